// File: rtl/lsu_rmw_if.sv
// Core request/response and data-memory signals of the load/store unit.
// slave is the LSU side, master is the core/memory environment side.
interface lsu_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_dout;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_din, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_din, mem_read, mem_write
    );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned requests with resp_err instead of aligning them down.
module lsu_rmw #(
    parameter int ADDR_W        = 32,
    parameter int RESP_ON_STORE = 1
) (
    input  logic     clk,
    input  logic     reset,
    lsu_rmw_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // LOAD   | read word, extract and extend the addressed field
    // WRITE  | full-word write of wdata_q
    // RMW_RD | read the word that a sub-word store will merge into
    // RMW_WR | write back the merged word
    // RESP   | one-cycle completion
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              write_q;
    logic              err_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       merge_q;

    logic              req_is_word;
    logic              req_is_half;
    logic              go_err;
    logic              accept;
    logic [ADDR_W-1:0] addr_clr;
    logic [4:0]        bit_off;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    logic              ready_c;
    logic              read_c;
    logic              write_c;
    logic              valid_c;
    logic [31:0]       din_c;
    logic [31:0]       rdata_c;

    assign req_is_word = bus.req_size[1];
    assign req_is_half = (bus.req_size == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (req_is_half && bus.req_addr[0]) ||
                        (req_is_word && (bus.req_addr[1:0] != 2'b00));
    assign go_err     = misaligned;
`else
    assign go_err     = 1'b0;
`endif

    // Dropping the offending low bits makes a misaligned access fall back to its natural boundary.
    always_comb begin
        addr_clr = bus.req_addr;
        if (req_is_word) begin
            addr_clr[1:0] = 2'b00;
        end else if (req_is_half) begin
            addr_clr[0] = 1'b0;
        end
    end

    assign bit_off  = {addr_q[1:0], 3'b000};
    assign half_sel = addr_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];

    always_comb begin
        load_ext = bus.mem_dout;
        if (size_q == 2'b00) begin
            load_ext = {24'd0, bus.mem_dout[bit_off +: 8]};
            if (!unsigned_q) begin
                load_ext[31:8] = {24{load_ext[7]}};
            end
        end else if (size_q == 2'b01) begin
            load_ext = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
        end
    end

    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            merged[bit_off +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready_c   = 1'b0;
        read_c    = 1'b0;
        write_c   = 1'b0;
        valid_c   = 1'b0;
        din_c     = 32'd0;
        rdata_c   = 32'd0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (go_err) begin
                        state_nxt = RESP;
                    end else if (!bus.req_write) begin
                        state_nxt = LOAD;
                    end else if (req_is_word) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = RMW_RD;
                    end
                end
            end
            LOAD: begin
                read_c    = 1'b1;
                state_nxt = RESP;
            end
            WRITE: begin
                write_c   = 1'b1;
                din_c     = wdata_q;
                state_nxt = RESP;
            end
            RMW_RD: begin
                read_c    = 1'b1;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                write_c   = 1'b1;
                din_c     = merged;
                state_nxt = RESP;
            end
            RESP: begin
                valid_c   = !write_q || err_q || (RESP_ON_STORE != 0);
                rdata_c   = write_q ? 32'd0 : rdata_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rdata_q is cleared at accept so an error response carries zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            merge_q    <= 32'd0;
        end else begin
            if (accept) begin
                addr_q     <= addr_clr;
                size_q     <= bus.req_size;
                unsigned_q <= bus.req_unsigned;
                write_q    <= bus.req_write;
                err_q      <= go_err;
                wdata_q    <= bus.req_wdata;
                rdata_q    <= 32'd0;
            end
            if (state == LOAD) begin
                rdata_q <= load_ext;
            end
            if (state == RMW_RD) begin
                merge_q <= bus.mem_dout;
            end
        end
    end

    // Memory strobes are gated by reset so an abandoned store never lands.
    assign bus.req_ready  = ready_c;
    assign bus.mem_read   = read_c & ~reset;
    assign bus.mem_write  = write_c & ~reset;
    assign bus.mem_din    = din_c;
    assign bus.mem_addr   = (state != IDLE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.resp_valid = valid_c & ~reset;
    assign bus.resp_rdata = reset ? 32'd0 : rdata_c;

`ifdef LSU_MISALIGN_CHECK_EN
    assign bus.resp_err   = (state == RESP) && err_q && !reset;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed and randomized checks of lsu_rmw against a byte-level behavioural model of the
// load/store rules and a word memory with async read and sync write.
`timescale 1ns/1ps
module tb_lsu_rmw;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic preload = 1'b1;
    always #5 clk = ~clk;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    lsu_rmw_if #(.ADDR_W(32)) bus ();
    lsu_rmw #(.ADDR_W(32), .RESP_ON_STORE(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
        if (i == 32'h40) w = 32'h11223344;
        if (i == 32'h41) w = 32'h80FF7F00;
        if (i == 32'h42) w = 32'hFFFFFFFF;
        return w;
    endfunction

    assign bus.mem_dout = mem[bus.mem_addr[15:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16384; i++) mem[i] <= init_word(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[15:2]] <= bus.mem_din;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expectations from the driver; the compare process walks them with its own read indices
    int          exp_cyc_q[$];
    logic [31:0] exp_rdata_q[$];
    logic        exp_err_q[$];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    string       lit_name[$];
    logic [31:0] lit_act[$];
    logic [31:0] lit_exp[$];
    logic        cur_reads = 1'b0;
    logic [31:0] cur_addr = 32'd0;
    bit          mon_en = 1'b0;

    int          checks = 0, failures = 0;
    int          resp_rd = 0, wr_rd = 0, lit_rd = 0;
    int          n_reads = 0, n_writes = 0, last_resp_cyc = 0;
    logic [31:0] last_rdata = 0, last_wr_addr = 0, last_wr_data = 0;
    logic        last_err = 0;
    int          rd_base = 0, wr_base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_name.push_back(name);
        lit_act.push_back(act);
        lit_exp.push_back(exp);
    endtask

    always @(negedge clk) begin
        while (lit_rd < lit_name.size()) begin
            check(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
        if (reset) begin
            resp_rd = exp_cyc_q.size();
            wr_rd   = wq_addr.size();
        end
        if (mon_en) begin
            check("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
            if (bus.req_ready) check("idle_mem_addr", bus.mem_addr, 32'd0);
            if (bus.mem_read) begin
                n_reads++;
                check("read_allowed", {31'd0, cur_reads}, 32'd1);
                check("read_addr", bus.mem_addr, cur_addr);
            end
            if (bus.mem_write) begin
                n_writes++;
                last_wr_addr = bus.mem_addr;
                last_wr_data = bus.mem_din;
                if (wr_rd >= wq_addr.size()) begin
                    check("unexpected_write", {31'd0, bus.mem_write}, 32'd0);
                end else begin
                    check("write_addr", bus.mem_addr, wq_addr[wr_rd]);
                    check("write_data", bus.mem_din, wq_data[wr_rd]);
                    wr_rd++;
                end
            end
            if (bus.resp_valid) begin
                last_resp_cyc = cyc;
                last_rdata    = bus.resp_rdata;
                last_err      = bus.resp_err;
                if (resp_rd >= exp_cyc_q.size()) begin
                    check("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
                end else begin
                    check("resp_cycle", cyc, exp_cyc_q[resp_rd]);
                    check("resp_rdata", bus.resp_rdata, exp_rdata_q[resp_rd]);
                    check("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_err_q[resp_rd]});
                    resp_rd++;
                end
            end
        end
    end

    task automatic pulse_reset();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd, input bit abort, output int acc);
        bit          word, half, mis, reads, has_wr, err;
        logic [31:0] ea, waddr, old, v, mask, rdata, wexp;
        int          sh, lat;
        word  = sz[1];
        half  = (sz == 2'b01);
        mis   = (half && a[0]) || (word && (a[1:0] != 2'b00));
        ea    = a;
        if (word) ea[1:0] = 2'b00;
        else if (half) ea[0] = 1'b0;
        waddr = {ea[31:2], 2'b00};
        old   = ref_mem[ea[15:2]];
        sh    = 8 * int'(ea[1:0]);
        rdata = 32'd0; wexp = 32'd0; err = 1'b0; reads = 1'b0; has_wr = 1'b0; lat = 2;
        if (CHK && mis) begin
            lat = 1; err = 1'b1;
        end else if (!w) begin
            reads = 1'b1;
            if (word) begin
                rdata = old;
            end else begin
                mask = half ? 32'h0000FFFF : 32'h000000FF;
                v = (old >> sh) & mask;
                if (!uns && v > (mask >> 1)) v = v | ~mask;
                rdata = v;
            end
        end else if (word) begin
            has_wr = 1'b1; wexp = wd;
        end else begin
            lat = 3; reads = 1'b1; has_wr = 1'b1;
            mask = (half ? 32'h0000FFFF : 32'h000000FF) << sh;
            wexp = (old & ~mask) | ((wd << sh) & mask);
        end

        acc = -1;
        for (int t = 0; t < 20 && acc < 0; t++) begin
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
            bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
            if (bus.req_ready) begin
                acc = cyc + 1;
                cur_reads = reads; cur_addr = waddr;
                rd_base = n_reads; wr_base = n_writes;
                exp_cyc_q.push_back(acc + lat - 1);
                exp_rdata_q.push_back(rdata);
                exp_err_q.push_back(err);
                if (has_wr) begin
                    wq_addr.push_back(waddr);
                    wq_data.push_back(wexp);
                end
            end
        end
        if (acc < 0) begin
            lit("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
            pulse_reset();
            return;
        end
        @(posedge clk);
        #1;
        if (abort) begin
            bus.req_valid = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            return;
        end
        if (has_wr) ref_mem[ea[15:2]] = wexp;
        // junk while busy must be ignored
        bus.req_valid = 1'b1; bus.req_write = 1'($urandom_range(0, 1));
        bus.req_size = 2'($urandom_range(0, 3)); bus.req_addr = $urandom; bus.req_wdata = $urandom;
        for (int t = 0; t < 20 && resp_rd != exp_cyc_q.size(); t++) begin
            @(negedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (resp_rd != exp_cyc_q.size()) begin
            lit("resp_timeout", exp_cyc_q.size() - resp_rd, 32'd0);
            pulse_reset();
        end
    endtask

    initial begin
        int acc, acc2, r1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        lit("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        lit("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        lit("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        lit("rst_resp_rdata", bus.resp_rdata, 32'd0);
        lit("rst_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        lit("rst_mem_din", bus.mem_din, 32'd0);
        lit("rst_mem_addr", bus.mem_addr, 32'd0);
        mon_en = 1'b1;

        issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB, 1'b0, acc);
        lit("rmw_din", last_wr_data, 32'h1122AB44);
        lit("rmw_addr", last_wr_addr, 32'h00000100);
        lit("rmw_latency", last_resp_cyc - acc + 1, 32'd3);
        lit("rmw_reads", n_reads - rd_base, 32'd1);
        lit("rmw_writes", n_writes - wr_base, 32'd1);

        issue(1'b0, 2'b00, 1'b0, 32'h106, 32'd0, 1'b0, acc);
        lit("lb_signed", last_rdata, 32'hFFFFFFFF);
        issue(1'b0, 2'b00, 1'b1, 32'h105, 32'd0, 1'b0, acc);
        lit("lbu", last_rdata, 32'h0000007F);
        issue(1'b0, 2'b01, 1'b0, 32'h106, 32'd0, 1'b0, acc);
        lit("lh_signed", last_rdata, 32'hFFFF80FF);

        issue(1'b1, 2'b01, 1'b0, 32'h10A, 32'h00001234, 1'b0, acc);
        lit("sh_merge", last_wr_data, 32'h1234FFFF);
        r1 = last_resp_cyc;
        issue(1'b0, 2'b10, 1'b0, 32'h108, 32'd0, 1'b0, acc2);
        lit("b2b_accept", acc2 - r1, 32'd2);
        lit("lw_after_sh", last_rdata, 32'h1234FFFF);

        issue(1'b1, 2'b10, 1'b0, 32'h108, 32'hDEADBEEF, 1'b0, acc);
        lit("sw_addr", last_wr_addr, 32'h00000108);
        lit("sw_writes", n_writes - wr_base, 32'd1);
        lit("sw_reads", n_reads - rd_base, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h108, 32'd0, 1'b0, acc);
        lit("lw_data", last_rdata, 32'hDEADBEEF);
        lit("lw_latency", last_resp_cyc - acc + 1, 32'd2);

        issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h00000055, 1'b1, acc);
        @(negedge clk);
        lit("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        lit("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        lit("abort_writes", n_writes - wr_base, 32'd0);
        lit("abort_mem_word", mem[32'h40], 32'h1122AB44);

        issue(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 1'b0, acc);
        lit("mis_err", {31'd0, last_err}, CHK ? 32'd1 : 32'd0);
        lit("mis_rdata", last_rdata, CHK ? 32'd0 : 32'h1122AB44);
        lit("mis_latency", last_resp_cyc - acc + 1, CHK ? 32'd1 : 32'd2);
        lit("mis_reads", n_reads - rd_base, CHK ? 32'd0 : 32'd1);

        for (int n = 0; n < 400; n++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h100 + 32'($urandom_range(0, 127)), $urandom, 1'b0, acc);
        end

        for (int t = 0; t < 10 && lit_rd != lit_name.size(); t++) @(negedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit directly upstream of the word-only data memory (async read, sync write, word index = addr[15:2]).
- Accepts byte, halfword and word requests from the core.
- Loads: aligns and sign/zero-extends the addressed field.
- Sub-word stores: read-modify-write (read word, merge, write back), since the memory has no byte enables.

Parameters:
- ADDR_W, 32, width of the core address and memory address
- RESP_ON_STORE, 1, when 1 stores also pulse resp_valid; when 0 only loads and errors respond

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  LSU can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned  input  1  zero-extend loads when 1
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data (0 for stores/errors)
- resp_err  output  1  misaligned access (qualified by resp_valid)
- mem_addr  output  ADDR_W  word-aligned address {addr_q[31:2],2'b00}
- mem_din  output  32  write data to memory
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_dout  input  32  memory read data (combinational)

Behaviour:
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
- Reset: state = IDLE. Reset values:
  - req_ready = 1
  - resp_valid = 0, resp_err = 0, resp_rdata = 0
  - mem_read = 0, mem_write = 0, mem_din = 0, mem_addr = 0
- Reset mid-operation:
  - Abandons the request with no response.
  - mem_write and mem_read are combinationally forced to 0 while reset is high, so no partial write lands.
- Accept rule:
  - Acceptance happens on req_valid && req_ready (IDLE only).
  - At acceptance, addr/size/unsigned/wdata/write are registered.
  - Request inputs are ignored in all other states.
- Transitions from IDLE:
  - load -> LOAD
  - word store -> WRITE
  - byte/half store -> RMW_RD
  - misaligned (see Optional Feature) -> RESP with error
- LOAD: mem_read = 1.
  - Select the byte by addr_q[1:0] or the half by addr_q[1]; extend per req_unsigned.
  - Capture into rdata_q; go to RESP.
- WRITE: mem_write = 1, mem_din = wdata_q; go to RESP.
- RMW_RD: mem_read = 1; capture mem_dout into merge_q; go to RMW_WR.
- RMW_WR: mem_write = 1, mem_din = merge_q with the target field replaced by wdata_q[7:0] or [15:0]; go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle (stores only if RESP_ON_STORE = 1; the state is still visited).
  - resp_rdata = rdata_q for loads, 0 otherwise.
  - Next state IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Back-to-back: the next request is accepted the cycle after RESP (req_ready high in IDLE). No pipelining.
- mem_addr is held at the aligned latched address in all non-IDLE states, 0 in IDLE.
- mem_read and mem_write are never asserted together.
- Halfword at addr[1:0] = 01/11 and word at addr[1:0] != 00 are misaligned.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned request produces no memory access.
  - It goes straight to RESP with resp_err = 1 and resp_rdata = 0.
  - resp_valid is asserted for errors regardless of RESP_ON_STORE.
- Undefined:
  - Offending low address bits are cleared (half uses addr[1] only; word ignores addr[1:0]).
  - The access proceeds normally; resp_err is tied to 0.

Test Plan:
- Memory word 0x100 = 0x11223344; byte store 0xAB at 0x101 -> RMW_RD then RMW_WR with mem_din = 0x1122AB44; resp_valid 3 cycles after accept.
- Word 0x104 = 0x80FF7F00; load byte signed at 0x106 -> resp_rdata 0xFFFFFFFF. Load byte unsigned at 0x105 -> 0x0000007F. Load half signed at 0x106 -> 0xFFFF80FF.
- Word store 0xDEADBEEF at 0x108 -> single mem_write cycle, mem_addr = 0x108; subsequent word load returns 0xDEADBEEF, 2-cycle latency.
- Half store 0x1234 at 0x10A over 0xFFFFFFFF -> memory 0x1234FFFF. Immediate next request accepted the cycle after resp_valid.
- Reset asserted during RMW_WR of byte 0x55 at 0x100 -> mem_write stays 0, word unchanged, req_ready = 1 and resp_valid = 0 after reset.
- With LSU_MISALIGN_CHECK_EN: word load at 0x102 -> resp_err = 1 one cycle after accept, no mem_read. Without the macro: same request reads word 0x100.
